// File: rtl/fphub_divider_ctrl.sv
// fphub_divider_ctrl: sequences load/iterate/normalize strobes for the iterative FPHUB divider, with special-case bypass.
module fphub_divider_ctrl #(
  parameter int M = 23,
  parameter int E = 8,
  parameter int special_case = 7,
  parameter int ITERS = M + 2,
  localparam int SCW = $clog2(special_case),
  localparam int CW = $clog2(ITERS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SCW-1:0] x_sc,
  input  logic [SCW-1:0] y_sc,
  output logic           op_load,
  output logic [SCW-1:0] x_sc_q,
  output logic [SCW-1:0] y_sc_q,
  output logic           dp_load,
  output logic           dp_iter_en,
  output logic [CW-1:0]  iter_idx,
  output logic           dp_norm_en,
  output logic           sel_special,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);
  if (ITERS < 1 || M < 1 || E < 1) begin : g_bad_params
    $error("fphub_divider_ctrl: ITERS, M and E must be >= 1");
  end
  typedef enum logic [2:0] {IDLE, LOAD, ITER, NORM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic special;
  assign special = |{x_sc, y_sc};
  assign in_ready = state == IDLE;
  assign op_load = in_valid & in_ready;
  assign dp_load = state == LOAD;
  assign dp_iter_en = state == ITER;
  assign dp_norm_en = state == NORM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign iter_idx = state == ITER ? cnt : '0;
  always_comb begin
    state_n = state == IDLE ? (op_load ? (special ? DONE : LOAD) : IDLE) :
              state == LOAD ? ITER :
              state == ITER ? (cnt == '0 ? NORM : ITER) :
              state == NORM ? DONE :
              (state == DONE && !out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      x_sc_q <= '0;
      y_sc_q <= '0;
      sel_special <= 1'b0;
    end else begin
      state <= state_n;
      if (op_load) begin
        x_sc_q <= x_sc;
        y_sc_q <= y_sc;
        sel_special <= special;
      end
      if (state == LOAD) cnt <= CW'(ITERS - 1);
      else if (state == ITER && cnt != '0) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_fphub_divider_ctrl.sv
// tb_fphub_divider_ctrl: vector table, random ops against a latency/pulse-count model, reset and ITERS=1 corners.
module tb_fphub_divider_ctrl;
  localparam int ITERS = 25;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic in_valid = 0, out_ready = 0;
  logic [2:0] x_sc = 0, y_sc = 0;
  logic in_ready, op_load, dp_load, dp_iter_en, dp_norm_en, sel_special, out_valid, busy;
  logic [2:0] x_sc_q, y_sc_q;
  logic [4:0] iter_idx;

  fphub_divider_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_sc(x_sc), .y_sc(y_sc),
    .op_load(op_load), .x_sc_q(x_sc_q), .y_sc_q(y_sc_q), .dp_load(dp_load), .dp_iter_en(dp_iter_en),
    .iter_idx(iter_idx), .dp_norm_en(dp_norm_en), .sel_special(sel_special), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  logic s_in_valid = 0, s_out_ready = 0;
  logic [2:0] s_x_sc = 0, s_y_sc = 0;
  logic s_in_ready, s_op_load, s_dp_load, s_dp_iter_en, s_dp_norm_en, s_sel_special, s_out_valid, s_busy;
  logic [2:0] s_x_sc_q, s_y_sc_q;
  logic [0:0] s_iter_idx;

  fphub_divider_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .x_sc(s_x_sc), .y_sc(s_y_sc),
    .op_load(s_op_load), .x_sc_q(s_x_sc_q), .y_sc_q(s_y_sc_q), .dp_load(s_dp_load), .dp_iter_en(s_dp_iter_en),
    .iter_idx(s_iter_idx), .dp_norm_en(s_dp_norm_en), .sel_special(s_sel_special), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .busy(s_busy));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " strobes"}, {dp_load, dp_iter_en, dp_norm_en}, 0);
    chk({tag, " iter_idx"}, iter_idx, 0);
    chk({tag, " codes_q"}, {x_sc_q, y_sc_q}, 0);
    chk({tag, " sel_special"}, sel_special, 0);
  endtask

  // Called at a negedge with the controller idle; returns at the negedge of the post-handoff IDLE bubble.
  // Expected behaviour comes only from the codes: special -> 1-cycle bypass, else LOAD + ITERS + NORM.
  task automatic run_op(input logic [2:0] xs, input logic [2:0] ys, input int dly, input bit keep_valid);
    bit sp;
    int lat, nl, ni, nn, exp_idx, idx_bad;
    sp = (xs != 0) || (ys != 0);
    in_valid = 1; x_sc = xs; y_sc = ys; out_ready = 0;
    #1 chk("accept op_load", op_load, 1);
    @(negedge clk);
    in_valid = keep_valid;
    lat = 1; nl = 0; ni = 0; nn = 0; exp_idx = ITERS - 1; idx_bad = 0;
    while (!out_valid && lat < 200) begin
      if (dp_load) nl++;
      if (dp_norm_en) nn++;
      if (dp_iter_en) begin
        if (iter_idx != 5'(exp_idx)) idx_bad++;
        exp_idx--; ni++;
      end
      if (in_ready || !busy) idx_bad += 100;
      x_sc = 3'($urandom); y_sc = 3'($urandom);
      #1 if (op_load) idx_bad += 1000;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, sp ? 1 : ITERS + 3);
    chk("sel_special", sel_special, sp);
    chk("x_sc_q", x_sc_q, xs);
    chk("y_sc_q", y_sc_q, ys);
    chk("dp_load pulses", nl, sp ? 0 : 1);
    chk("dp_iter pulses", ni, sp ? 0 : ITERS);
    chk("dp_norm pulses", nn, sp ? 0 : 1);
    chk("iter idx/busy/op_load errors", idx_bad, 0);
    for (int d = 0; d < dly; d++) begin
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
      chk("hold codes", {x_sc_q, y_sc_q, sel_special}, {xs, ys, sp});
      #1 chk("hold op_load", op_load, 0);
      @(negedge clk);
    end
    chk("handoff out_valid", out_valid, 1);
    out_ready = 1; in_valid = 0;
    @(negedge clk);
    out_ready = 0;
    chk("bubble out_valid", out_valid, 0);
    chk("bubble in_ready", in_ready, 1);
  endtask

  typedef struct {logic [2:0] xs; logic [2:0] ys; int dly; bit keep;} vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{3, 3, 0, 0};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{0, 0, 5, 1};
    vecs[3] = '{0, 5, 0, 0};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{7, 0, 2, 1};
    vecs[6] = '{0, 6, 1, 0};

    repeat (2) @(negedge clk);
    rst = 0;
    chk_idle_reset("por");

    foreach (vecs[i]) run_op(vecs[i].xs, vecs[i].ys, vecs[i].dly, vecs[i].keep);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] xs, ys;
      xs = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      ys = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      run_op(xs, ys, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset while parked in DONE with nonzero codes latched.
    in_valid = 1; x_sc = 5; y_sc = 6;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("parked out_valid", out_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_idle_reset("rst in DONE");

    // Reset for two cycles mid-ITER at iter_idx 10.
    begin
      int t = 0;
      in_valid = 1; x_sc = 0; y_sc = 0;
      @(negedge clk);
      in_valid = 0;
      while (!(dp_iter_en && iter_idx == 10) && t < 100) begin @(negedge clk); t++; end
      chk("reach iter_idx 10", {dp_iter_en, iter_idx}, {1'b1, 5'd10});
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      chk_idle_reset("rst in ITER");
      out_ready = 1; t = 0;
      repeat (40) begin @(negedge clk); if (out_valid || busy) t++; end
      out_ready = 0;
      chk("no stale activity", t, 0);
    end

    // ITERS=1 instance: LOAD, one ITER at idx 0, NORM, out_valid at accept+4.
    begin
      logic [3:0] exp_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
      s_in_valid = 1; s_out_ready = 1;
      #1 chk("iters1 op_load", s_op_load, 1);
      @(negedge clk);
      s_in_valid = 0;
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("iters1 cycle%0d", c + 1), {s_dp_load, s_dp_iter_en, s_dp_norm_en, s_out_valid}, exp_seq[c]);
        if (s_dp_iter_en) chk("iters1 iter_idx", s_iter_idx, 0);
        @(negedge clk);
      end
      chk("iters1 sel_special", s_sel_special, 0);
      chk("iters1 in_ready", s_in_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
